core_dmem_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the RV32I pipeline. It is the producer of the data-memory busy/done status that the hazard control unit consumes. It accepts a single-shot load or store request from the EXMEM stage, runs one transaction on a valid/ready data bus, aligns and sign-extends load data, and forms byte strobes for stores. It holds `HCU_DMEM_BUSY` for the whole access and pulses `HCU_DMEM_DONE` when the result is ready for MEMWB.

---
 rtl/core_dmem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_core_dmem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_ctrl.sv
// MEM-stage data-memory controller: runs one valid/ready bus transaction per load/store
// strobe, aligns/extends load data, builds store strobes and reports busy/done to the HCU.
module core_dmem_ctrl (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        C_ISLOAD_SS,
    input  logic        C_ISSTORE_SS,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] LOAD_DATA,
    output logic        DMEM_ERR,
    output logic        HCU_DMEM_BUSY,
    output logic        HCU_DMEM_DONE,
    output logic        M_REQ_VALID,
    input  logic        M_REQ_READY,
    output logic        M_REQ_WE,
    output logic [31:0] M_REQ_ADDR,
    output logic [3:0]  M_REQ_WSTRB,
    output logic [31:0] M_REQ_WDATA,
    input  logic        M_RSP_VALID,
    input  logic [31:0] M_RSP_RDATA,
    input  logic        M_RSP_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        we_r;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic [3:0]  wstrb_r;
    logic [31:0] wdata_r;
    logic        err_r;
    logic [31:0] load_data_r;

    logic        start_s;
    logic        illegal_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;

    function automatic logic access_illegal(input logic is_load, input logic is_store,
                                            input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        if (is_load && is_store) begin
            bad = 1'b1;
        end else if (is_load) begin
            case (f3)
                3'd3, 3'd6, 3'd7: bad = 1'b1;
                default:          bad = 1'b0;
            endcase
        end else begin
            bad = (f3 >= 3'd3);
        end
        // Alignment: halfwords need an even address, words a 4-byte aligned one.
        bad = bad | ((f3[1:0] == 2'd1) & lane[0]) | ((f3[1:0] == 2'd2) & (lane != 2'd0));
        return bad;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd4:    res = {24'd0, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd5:    res = {16'd0, h};
            3'd2:    res = rdata;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign start_s   = C_ISLOAD_SS | C_ISSTORE_SS;
    assign illegal_s = access_illegal(C_ISLOAD_SS, C_ISSTORE_SS, FUNCT3, ADDR[1:0]);

    // Store lane strobes and replicated write data; reads carry no strobes.
    always_comb begin
        wstrb_s = 4'b0000;
        wdata_s = 32'd0;
        if (C_ISSTORE_SS && !C_ISLOAD_SS) begin
            case (FUNCT3)
                3'd0: begin
                    wstrb_s = 4'b0001 << ADDR[1:0];
                    wdata_s = {4{WDATA[7:0]}};
                end
                3'd1: begin
                    wstrb_s = 4'b0011 << {ADDR[1], 1'b0};
                    wdata_s = {2{WDATA[15:0]}};
                end
                3'd2: begin
                    wstrb_s = 4'b1111;
                    wdata_s = WDATA;
                end
                default: begin
                    wstrb_s = 4'b0000;
                    wdata_s = 32'd0;
                end
            endcase
        end else begin
            wstrb_s = 4'b0000;
            wdata_s = 32'd0;
        end
    end

    // Next-state decode; strobes only matter in IDLE, bus response only in RSP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = illegal_s ? ST_DONE : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (M_REQ_READY) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (M_RSP_VALID) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latched request fields, captured error and load result.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            funct3_r    <= 3'd0;
            wstrb_r     <= 4'b0000;
            wdata_r     <= 32'd0;
            err_r       <= 1'b0;
            load_data_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && start_s) begin
                we_r     <= C_ISSTORE_SS & ~C_ISLOAD_SS;
                addr_r   <= ADDR;
                funct3_r <= FUNCT3;
                wstrb_r  <= wstrb_s;
                wdata_r  <= wdata_s;
                err_r    <= illegal_s;
                if (illegal_s) begin
                    load_data_r <= 32'd0;
                end else begin
                    load_data_r <= load_data_r;
                end
            end else if ((state_r == ST_RSP) && M_RSP_VALID) begin
                err_r <= M_RSP_ERR;
                if (M_RSP_ERR) begin
                    load_data_r <= 32'd0;
                end else if (!we_r) begin
                    load_data_r <= extract_load(funct3_r, addr_r[1:0], M_RSP_RDATA);
                end else begin
                    load_data_r <= load_data_r;
                end
            end else begin
                err_r       <= err_r;
                load_data_r <= load_data_r;
            end
        end
    end

    assign HCU_DMEM_BUSY = (state_r == ST_REQ) || (state_r == ST_RSP);
    assign HCU_DMEM_DONE = (state_r == ST_DONE);
    assign DMEM_ERR      = (state_r == ST_DONE) & err_r;
    assign LOAD_DATA     = load_data_r;
    assign M_REQ_VALID   = (state_r == ST_REQ);
    assign M_REQ_WE      = we_r;
    assign M_REQ_ADDR    = {addr_r[31:2], 2'b00};
    assign M_REQ_WSTRB   = wstrb_r;
    assign M_REQ_WDATA   = wdata_r;

endmodule

// File: tb/tb_core_dmem_ctrl.sv
// Directed bench for core_dmem_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_core_dmem_ctrl;

    logic        CLK;
    logic        NRST;
    logic        C_ISLOAD_SS;
    logic        C_ISSTORE_SS;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [31:0] LOAD_DATA;
    logic        DMEM_ERR;
    logic        HCU_DMEM_BUSY;
    logic        HCU_DMEM_DONE;
    logic        M_REQ_VALID;
    logic        M_REQ_READY;
    logic        M_REQ_WE;
    logic [31:0] M_REQ_ADDR;
    logic [3:0]  M_REQ_WSTRB;
    logic [31:0] M_REQ_WDATA;
    logic        M_RSP_VALID;
    logic [31:0] M_RSP_RDATA;
    logic        M_RSP_ERR;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int req_cnt;
    int done_cyc;
    logic err_seen;
    logic [31:0] ld_seen;
    logic stable_bad;

    core_dmem_ctrl dut (
        .CLK(CLK), .NRST(NRST),
        .C_ISLOAD_SS(C_ISLOAD_SS), .C_ISSTORE_SS(C_ISSTORE_SS),
        .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
        .LOAD_DATA(LOAD_DATA), .DMEM_ERR(DMEM_ERR),
        .HCU_DMEM_BUSY(HCU_DMEM_BUSY), .HCU_DMEM_DONE(HCU_DMEM_DONE),
        .M_REQ_VALID(M_REQ_VALID), .M_REQ_READY(M_REQ_READY), .M_REQ_WE(M_REQ_WE),
        .M_REQ_ADDR(M_REQ_ADDR), .M_REQ_WSTRB(M_REQ_WSTRB), .M_REQ_WDATA(M_REQ_WDATA),
        .M_RSP_VALID(M_RSP_VALID), .M_RSP_RDATA(M_RSP_RDATA), .M_RSP_ERR(M_RSP_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse a start strobe for one cycle; returns at the falling edge of cycle 1.
    task automatic start(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        C_ISLOAD_SS  = ld;
        C_ISSTORE_SS = st;
        FUNCT3       = f3;
        ADDR         = a;
        WDATA        = wd;
        @(negedge CLK);
        C_ISLOAD_SS  = 1'b0;
        C_ISSTORE_SS = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld"},    LOAD_DATA, 32'd0);
        chk({tag, "_err"},   {31'd0, DMEM_ERR}, 32'd0);
        chk({tag, "_busy"},  {31'd0, HCU_DMEM_BUSY}, 32'd0);
        chk({tag, "_done"},  {31'd0, HCU_DMEM_DONE}, 32'd0);
        chk({tag, "_valid"}, {31'd0, M_REQ_VALID}, 32'd0);
        chk({tag, "_we"},    {31'd0, M_REQ_WE}, 32'd0);
        chk({tag, "_addr"},  M_REQ_ADDR, 32'd0);
        chk({tag, "_strb"},  {28'd0, M_REQ_WSTRB}, 32'd0);
        chk({tag, "_wdata"}, M_REQ_WDATA, 32'd0);
    endtask

    initial begin
        NRST = 1'b0; C_ISLOAD_SS = 1'b0; C_ISSTORE_SS = 1'b0;
        FUNCT3 = 3'd0; ADDR = 32'd0; WDATA = 32'd0;
        M_REQ_READY = 1'b1; M_RSP_VALID = 1'b1; M_RSP_RDATA = 32'h80FF_1234; M_RSP_ERR = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge CLK);
        NRST = 1'b1;
        @(negedge CLK);

        // LB from lane 3, zero-wait bus
        start(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'd0);
        chk("lb_c1_valid", {31'd0, M_REQ_VALID}, 32'd1);
        chk("lb_c1_addr", M_REQ_ADDR, 32'h0000_1000);
        chk("lb_c1_we", {31'd0, M_REQ_WE}, 32'd0);
        chk("lb_c1_strb", {28'd0, M_REQ_WSTRB}, 32'd0);
        chk("lb_c1_busy", {31'd0, HCU_DMEM_BUSY}, 32'd1);
        @(negedge CLK);
        chk("lb_c2_busy", {31'd0, HCU_DMEM_BUSY}, 32'd1);
        chk("lb_c2_valid", {31'd0, M_REQ_VALID}, 32'd0);
        chk("lb_c2_done", {31'd0, HCU_DMEM_DONE}, 32'd0);
        @(negedge CLK);
        chk("lb_c3_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("lb_c3_busy", {31'd0, HCU_DMEM_BUSY}, 32'd0);
        chk("lb_c3_ld", LOAD_DATA, 32'hFFFF_FF80);
        chk("lb_c3_err", {31'd0, DMEM_ERR}, 32'd0);
        @(negedge CLK);
        chk("lb_c4_done", {31'd0, HCU_DMEM_DONE}, 32'd0);
        chk("lb_c4_hold", LOAD_DATA, 32'hFFFF_FF80);

        // LBU, same address and data
        start(1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("lbu_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("lbu_ld", LOAD_DATA, 32'h0000_0080);
        @(negedge CLK);

        // SH to upper half
        start(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF);
        chk("sh_valid", {31'd0, M_REQ_VALID}, 32'd1);
        chk("sh_addr", M_REQ_ADDR, 32'h0000_2000);
        chk("sh_we", {31'd0, M_REQ_WE}, 32'd1);
        chk("sh_strb", {28'd0, M_REQ_WSTRB}, 32'h0000_000C);
        chk("sh_wdata", M_REQ_WDATA, 32'hBEEF_BEEF);
        @(negedge CLK);
        @(negedge CLK);
        chk("sh_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("sh_err", {31'd0, DMEM_ERR}, 32'd0);
        chk("sh_ld_kept", LOAD_DATA, 32'h0000_0080);
        @(negedge CLK);

        // Misaligned LW: no bus request, DONE in cycle 1 with error
        start(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'd0);
        chk("mis_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("mis_err", {31'd0, DMEM_ERR}, 32'd1);
        chk("mis_ld", LOAD_DATA, 32'd0);
        chk("mis_busy", {31'd0, HCU_DMEM_BUSY}, 32'd0);
        chk("mis_valid", {31'd0, M_REQ_VALID}, 32'd0);
        @(negedge CLK);
        chk("mis_c2_done", {31'd0, HCU_DMEM_DONE}, 32'd0);
        chk("mis_c2_valid", {31'd0, M_REQ_VALID}, 32'd0);

        // Both strobes at once is illegal
        start(1'b1, 1'b1, 3'd2, 32'h0000_0000, 32'd0);
        chk("both_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("both_err", {31'd0, DMEM_ERR}, 32'd1);
        chk("both_valid", {31'd0, M_REQ_VALID}, 32'd0);
        @(negedge CLK);

        // LH with bus error; a second strobe during RSP must be ignored
        M_RSP_VALID = 1'b0;
        M_RSP_RDATA = 32'h5555_AAAA;
        start(1'b1, 1'b0, 3'd1, 32'h0000_4000, 32'd0);
        req_cnt = 0; done_cyc = 0; err_seen = 1'b0; ld_seen = 32'hFFFF_FFFF;
        for (int c = 1; c <= 6; c++) begin
            if (M_REQ_VALID) req_cnt++;
            if (HCU_DMEM_DONE) begin
                done_cyc = c;
                err_seen = DMEM_ERR;
                ld_seen  = LOAD_DATA;
            end
            C_ISLOAD_SS = (c == 2);
            M_RSP_VALID = (c == 3);
            M_RSP_ERR   = (c == 3);
            @(negedge CLK);
        end
        chk("lherr_reqs", req_cnt, 32'd1);
        chk("lherr_done_cyc", done_cyc, 32'd4);
        chk("lherr_err", {31'd0, err_seen}, 32'd1);
        chk("lherr_ld", ld_seen, 32'd0);

        // LW with READY late by 3 cycles and RSP_VALID late by 2
        M_REQ_READY = 1'b0;
        M_RSP_VALID = 1'b0;
        M_RSP_RDATA = 32'h1234_5678;
        start(1'b1, 1'b0, 3'd2, 32'h0000_5004, 32'd0);
        busy_cnt = 0; req_cnt = 0; done_cyc = 0; stable_bad = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (HCU_DMEM_BUSY) busy_cnt++;
            if (M_REQ_VALID) req_cnt++;
            if (HCU_DMEM_DONE) done_cyc = c;
            if (M_REQ_VALID && ((M_REQ_ADDR !== 32'h0000_5004) || (M_REQ_WE !== 1'b0) ||
                                (M_REQ_WSTRB !== 4'b0000))) stable_bad = 1'b1;
            M_REQ_READY = (c == 4);
            M_RSP_VALID = (c == 7);
            @(negedge CLK);
        end
        chk("wait_busy_cycles", busy_cnt, 32'd7);
        chk("wait_req_cycles", req_cnt, 32'd4);
        chk("wait_done_cyc", done_cyc, 32'd8);
        chk("wait_stable", {31'd0, stable_bad}, 32'd0);
        chk("wait_ld", LOAD_DATA, 32'h1234_5678);

        // Reset asserted while in RSP
        M_REQ_READY = 1'b1;
        M_RSP_VALID = 1'b0;
        start(1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'd0);
        @(negedge CLK);
        chk("rst_pre_busy", {31'd0, HCU_DMEM_BUSY}, 32'd1);
        #2 NRST = 1'b0;
        #1;
        chk_all_zero("rst_rsp");
        @(negedge CLK);
        NRST = 1'b1;
        M_RSP_VALID = 1'b1;
        M_RSP_RDATA = 32'hCAFE_F00D;
        done_cyc = 0; busy_cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            if (HCU_DMEM_DONE) done_cyc = c;
            if (HCU_DMEM_BUSY) busy_cnt++;
        end
        chk("stray_done", done_cyc, 32'd0);
        chk("stray_busy", busy_cnt, 32'd0);

        // LW after reset completes normally
        start(1'b1, 1'b0, 3'd2, 32'h0000_7008, 32'd0);
        chk("post_addr", M_REQ_ADDR, 32'h0000_7008);
        chk("post_valid", {31'd0, M_REQ_VALID}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        chk("post_done", {31'd0, HCU_DMEM_DONE}, 32'd1);
        chk("post_err", {31'd0, DMEM_ERR}, 32'd0);
        chk("post_ld", LOAD_DATA, 32'hCAFE_F00D);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
